// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core sequencer: FSM states, decoder flag bit
// positions, trap cause codes and pc_sel / wb_sel encodings.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst    = 4'd0,
    StFetch  = 4'd1,
    StFWait  = 4'd2,
    StDecode = 4'd3,
    StExec   = 4'd4,
    StMem    = 4'd5,
    StMWait  = 4'd6,
    StWb     = 4'd7,
    StTrap   = 4'd8,
    StSleep  = 4'd9
  } state_e;

  localparam int unsigned NumFlags = 48;

  // One-hot decoder flag positions; instruction classes occupy contiguous ranges.
  localparam int unsigned FlagLui    = 0;
  localparam int unsigned FlagAuipc  = 1;
  localparam int unsigned FlagJal    = 2;
  localparam int unsigned FlagJalr   = 3;
  localparam int unsigned FlagBeq    = 4;   // branches 4..9
  localparam int unsigned FlagBgeu   = 9;
  localparam int unsigned FlagLb     = 10;  // loads 10..14
  localparam int unsigned FlagLw     = 12;
  localparam int unsigned FlagLhu    = 14;
  localparam int unsigned FlagSb     = 15;  // stores 15..17
  localparam int unsigned FlagSw     = 17;
  localparam int unsigned FlagAddi   = 18;  // immediate ALU 18..26
  localparam int unsigned FlagSrai   = 26;
  localparam int unsigned FlagAdd    = 27;  // register ALU 27..36
  localparam int unsigned FlagAnd    = 36;
  localparam int unsigned FlagEcall  = 37;
  localparam int unsigned FlagEbreak = 38;
  localparam int unsigned FlagMret   = 39;
  localparam int unsigned FlagSret   = 40;
  localparam int unsigned FlagWfi    = 41;
  localparam int unsigned FlagCsrrw  = 42;  // CSR ops 42..47
  localparam int unsigned FlagCsrrs  = 43;
  localparam int unsigned FlagCsrrci = 47;

  localparam logic [3:0] CauseIllegal = 4'd2;
  localparam logic [3:0] CauseBreak   = 4'd3;
  localparam logic [3:0] CauseEcall   = 4'd11;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcTarget = 2'd1;
  localparam logic [1:0] PcTrap   = 2'd2;
  localparam logic [1:0] PcEpc    = 2'd3;

  localparam logic [1:0] WbAlu = 2'd0;
  localparam logic [1:0] WbMem = 2'd1;
  localparam logic [1:0] WbPc4 = 2'd2;
  localparam logic [1:0] WbCsr = 2'd3;

  // True when any flag in [lo, hi] is set.
  function automatic logic any_in_range(input logic [NumFlags-1:0] flags,
                                        input int unsigned lo, input int unsigned hi);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NumFlags; i++) begin
      if (i >= lo && i <= hi) hit = hit | flags[i];
    end
    return hit;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshakes between the sequencer and memories.
interface core_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic imem_valid;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  logic dmem_valid;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, imem_valid, dmem_ready, dmem_valid
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, imem_valid, dmem_ready, dmem_valid
  );
endinterface

// File: rtl/wb_ctrl_map.sv
// Combinational write-back control: maps latched decoder flags and the branch
// compare result to register-file, CSR and PC-select controls.
module wb_ctrl_map
  import core_ctrl_pkg::*;
(
  input  logic [NumFlags-1:0] i_flags,
  input  logic                i_br_taken,
  output logic                o_rf_we,
  output logic [1:0]          o_wb_sel,
  output logic [1:0]          o_pc_sel,
  output logic                o_csr_we
);

  logic w_jump, w_branch, w_load, w_store, w_imm_alu, w_alu, w_csr, w_ret, w_sys;
  logic w_writer, w_no_wb;

  // Classify the instruction and derive write-back controls.
  always_comb begin
    w_jump    = i_flags[FlagJal] | i_flags[FlagJalr];
    w_branch  = any_in_range(i_flags, FlagBeq, FlagBgeu);
    w_load    = any_in_range(i_flags, FlagLb, FlagLhu);
    w_store   = any_in_range(i_flags, FlagSb, FlagSw);
    w_imm_alu = any_in_range(i_flags, FlagAddi, FlagSrai);
    w_alu     = any_in_range(i_flags, FlagAdd, FlagAnd);
    w_csr     = any_in_range(i_flags, FlagCsrrw, FlagCsrrci);
    w_ret     = i_flags[FlagMret] | i_flags[FlagSret];
    w_sys     = i_flags[FlagEcall] | i_flags[FlagEbreak] | i_flags[FlagWfi];

    w_writer = w_alu | w_imm_alu | i_flags[FlagLui] | i_flags[FlagAuipc] | w_jump | w_load | w_csr;
    // A malformed multi-hot flag set must never write the register file for
    // an instruction class that has no destination.
    w_no_wb  = w_sys | w_store | w_branch | w_ret;

    o_rf_we  = w_writer & ~w_no_wb;
    o_csr_we = w_csr;

    o_pc_sel = PcPlus4;
    if (w_ret) begin
      o_pc_sel = PcEpc;
    end else if (w_jump || (w_branch && i_br_taken)) begin
      o_pc_sel = PcTarget;
    end

    o_wb_sel = WbAlu;
    if (w_load) begin
      o_wb_sel = WbMem;
    end else if (w_jump) begin
      o_wb_sel = WbPc4;
    end else if (w_csr) begin
      o_wb_sel = WbCsr;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch / decode / execute / memory /
// write-back with trap and sleep handling. All strobes are decoded from the
// current state so that reset forces every output low immediately.
module core_sequencer
  import core_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                boot_en,
  core_sequencer_if.master    mem,
  output logic                ir_we,
  output logic                dec_en,
  input  logic [NumFlags-1:0] inst_flags,
  input  logic                invalid_instruction,
  input  logic                br_taken,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                csr_we,
  output logic                trap_req,
  output logic [3:0]          trap_cause,
  input  logic                irq,
  output logic [3:0]          state
);

  state_e              r_state, w_state_next;
  logic [NumFlags-1:0] r_flags;
  logic                r_invalid;

  logic       w_imem_req, w_dmem_req, w_dmem_we;
  logic       w_map_rf_we, w_map_csr_we;
  logic [1:0] w_map_wb_sel, w_map_pc_sel;
  logic       w_is_mem_op, w_is_store;

  wb_ctrl_map u_wb_ctrl_map (
    .i_flags    (r_flags),
    .i_br_taken (br_taken),
    .o_rf_we    (w_map_rf_we),
    .o_wb_sel   (w_map_wb_sel),
    .o_pc_sel   (w_map_pc_sel),
    .o_csr_we   (w_map_csr_we)
  );

  assign w_is_store  = any_in_range(r_flags, FlagSb, FlagSw);
  assign w_is_mem_op = w_is_store | any_in_range(r_flags, FlagLb, FlagLhu);

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRst;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Decoder outputs are captured once, at the end of DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_invalid <= 1'b0;
    end else if (r_state == StDecode) begin
      r_flags   <= inst_flags;
      r_invalid <= invalid_instruction;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_imem_req   = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    ir_we        = 1'b0;
    dec_en       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WbAlu;
    pc_we        = 1'b0;
    pc_sel       = PcPlus4;
    csr_we       = 1'b0;
    trap_req     = 1'b0;
    trap_cause   = 4'd0;

    unique case (r_state)
      StRst: begin
        if (boot_en) w_state_next = StFetch;
      end
      StFetch: begin
        w_imem_req = 1'b1;
        if (mem.imem_ready) w_state_next = StFWait;
      end
      StFWait: begin
        if (mem.imem_valid) begin
          ir_we        = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        dec_en = 1'b1;
        if (invalid_instruction || inst_flags[FlagEcall] || inst_flags[FlagEbreak]) begin
          w_state_next = StTrap;
        end else if (inst_flags[FlagWfi]) begin
          w_state_next = StSleep;
        end else begin
          w_state_next = StExec;
        end
      end
      StExec: begin
        w_state_next = w_is_mem_op ? StMem : StWb;
      end
      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_store;
        if (mem.dmem_ready) w_state_next = StMWait;
      end
      StMWait: begin
        if (mem.dmem_valid) w_state_next = StWb;
      end
      StWb: begin
        pc_we        = 1'b1;
        rf_we        = w_map_rf_we;
        wb_sel       = w_map_wb_sel;
        pc_sel       = w_map_pc_sel;
        csr_we       = w_map_csr_we;
        w_state_next = StFetch;
      end
      StTrap: begin
        trap_req = 1'b1;
        pc_we    = 1'b1;
        pc_sel   = PcTrap;
        // Same priority as the DECODE trap decision, from the latched copy.
        if (r_invalid) begin
          trap_cause = CauseIllegal;
        end else if (r_flags[FlagEcall]) begin
          trap_cause = CauseEcall;
        end else begin
          trap_cause = CauseBreak;
        end
        w_state_next = StFetch;
      end
      StSleep: begin
        if (irq) w_state_next = StWb;
      end
      default: begin
        w_state_next = StRst;
      end
    endcase
  end

  assign mem.imem_req = w_imem_req;
  assign mem.dmem_req = w_dmem_req;
  assign mem.dmem_we  = w_dmem_we;
  assign state        = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: inputs change on the falling edge and
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_core_sequencer;
  import core_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        boot_en;
  logic        ir_we, dec_en, rf_we, pc_we, csr_we, trap_req;
  logic [47:0] inst_flags;
  logic        invalid_instruction, br_taken, irq;
  logic [1:0]  wb_sel, pc_sel;
  logic [3:0]  trap_cause, state;
  logic [8:0]  strb;

  int n_tests = 0;
  int n_fail  = 0;

  core_sequencer_if mem_if ();

  core_sequencer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .boot_en             (boot_en),
    .mem                 (mem_if),
    .ir_we               (ir_we),
    .dec_en              (dec_en),
    .inst_flags          (inst_flags),
    .invalid_instruction (invalid_instruction),
    .br_taken            (br_taken),
    .rf_we               (rf_we),
    .wb_sel              (wb_sel),
    .pc_we               (pc_we),
    .pc_sel              (pc_sel),
    .csr_we              (csr_we),
    .trap_req            (trap_req),
    .trap_cause          (trap_cause),
    .irq                 (irq),
    .state               (state)
  );

  // Strobe vector: imem_req ir_we dec_en dmem_req dmem_we rf_we pc_we csr_we trap_req
  assign strb = {mem_if.imem_req, ir_we, dec_en, mem_if.dmem_req, mem_if.dmem_we,
                 rf_we, pc_we, csr_we, trap_req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] onehot(input int unsigned idx);
    logic [47:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, then check state and the strobe vector.
  task automatic at(input string tag, input logic [3:0] st, input logic [8:0] s);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_strb"}, 32'(strb), 32'(s));
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  // Zero-wait fetch from FETCH through DECODE; returns at the cycle after DECODE.
  task automatic fetch0(input logic [47:0] flags, input logic inv);
    boot_en = 1'b0;
    mem_if.imem_ready = 1'b1;
    at("fetch", StFetch, 9'h100);
    nxt;
    mem_if.imem_ready = 1'b0;
    mem_if.imem_valid = 1'b1;
    at("fwait", StFWait, 9'h080);
    nxt;
    mem_if.imem_valid = 1'b0;
    inst_flags = flags;
    invalid_instruction = inv;
    at("decode", StDecode, 9'h040);
    nxt;
    inst_flags = '0;
    invalid_instruction = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    boot_en = 1'b0;
    inst_flags = '0;
    invalid_instruction = 1'b0;
    br_taken = 1'b0;
    irq = 1'b0;
    mem_if.imem_ready = 1'b0;
    mem_if.imem_valid = 1'b0;
    mem_if.dmem_ready = 1'b0;
    mem_if.dmem_valid = 1'b0;

    // Reset state
    nxt;
    at("reset", StRst, 9'h000);
    chk("reset_wb_sel", 32'(wb_sel), 32'd0);
    chk("reset_pc_sel", 32'(pc_sel), 32'd0);
    chk("reset_cause", 32'(trap_cause), 32'd0);
    nxt;
    rst_n = 1'b1;
    at("rst_no_boot", StRst, 9'h000);
    nxt;
    boot_en = 1'b1;
    at("rst_boot", StRst, 9'h000);
    nxt;

    // imem_valid while still in FETCH must not load IR
    boot_en = 1'b0;
    mem_if.imem_valid = 1'b1;
    at("fetch_stall", StFetch, 9'h100);
    nxt;
    mem_if.imem_valid = 1'b0;

    // addi: WB is the fifth cycle after FETCH entry
    fetch0(onehot(FlagAddi), 1'b0);
    at("addi_exec", StExec, 9'h000);
    nxt;
    at("addi_wb", StWb, 9'h00C);
    chk("addi_wb_sel", 32'(wb_sel), 32'(WbAlu));
    chk("addi_pc_sel", 32'(pc_sel), 32'(PcPlus4));
    nxt;

    // lw with dmem_ready after 3 wait cycles: request held 4 cycles
    fetch0(onehot(FlagLw), 1'b0);
    at("lw_exec", StExec, 9'h000);
    nxt;
    for (int i = 0; i < 4; i++) begin
      mem_if.dmem_ready = (i == 3);
      at("lw_mem", StMem, 9'h020);
      nxt;
    end
    mem_if.dmem_ready = 1'b0;
    mem_if.dmem_valid = 1'b1;
    at("lw_mwait", StMWait, 9'h000);
    nxt;
    mem_if.dmem_valid = 1'b0;
    at("lw_wb", StWb, 9'h00C);
    chk("lw_wb_sel", 32'(wb_sel), 32'(WbMem));
    nxt;

    // sw with zero-wait data memory
    fetch0(onehot(FlagSw), 1'b0);
    at("sw_exec", StExec, 9'h000);
    nxt;
    mem_if.dmem_ready = 1'b1;
    at("sw_mem", StMem, 9'h030);
    nxt;
    mem_if.dmem_ready = 1'b0;
    mem_if.dmem_valid = 1'b1;
    at("sw_mwait", StMWait, 9'h000);
    nxt;
    mem_if.dmem_valid = 1'b0;
    at("sw_wb", StWb, 9'h004);
    nxt;

    // beq taken, then not taken
    fetch0(onehot(FlagBeq), 1'b0);
    at("beq1_exec", StExec, 9'h000);
    nxt;
    br_taken = 1'b1;
    at("beq1_wb", StWb, 9'h004);
    chk("beq1_pc_sel", 32'(pc_sel), 32'(PcTarget));
    nxt;
    br_taken = 1'b0;
    fetch0(onehot(FlagBeq), 1'b0);
    at("beq0_exec", StExec, 9'h000);
    nxt;
    at("beq0_wb", StWb, 9'h004);
    chk("beq0_pc_sel", 32'(pc_sel), 32'(PcPlus4));
    nxt;

    // jal: link register written with PC+4, PC to target
    fetch0(onehot(FlagJal), 1'b0);
    nxt;
    at("jal_wb", StWb, 9'h00C);
    chk("jal_wb_sel", 32'(wb_sel), 32'(WbPc4));
    chk("jal_pc_sel", 32'(pc_sel), 32'(PcTarget));
    nxt;

    // csrrs: register and CSR both written
    fetch0(onehot(FlagCsrrs), 1'b0);
    nxt;
    at("csr_wb", StWb, 9'h00E);
    chk("csr_wb_sel", 32'(wb_sel), 32'(WbCsr));
    nxt;

    // mret: return to epc, no register write
    fetch0(onehot(FlagMret), 1'b0);
    nxt;
    at("mret_wb", StWb, 9'h004);
    chk("mret_pc_sel", 32'(pc_sel), 32'(PcEpc));
    nxt;

    // Illegal instruction outranks the decoded flag
    fetch0(onehot(FlagAddi), 1'b1);
    at("ill_trap", StTrap, 9'h005);
    chk("ill_cause", 32'(trap_cause), 32'(CauseIllegal));
    chk("ill_pc_sel", 32'(pc_sel), 32'(PcTrap));
    nxt;

    fetch0(onehot(FlagEcall), 1'b0);
    at("ecall_trap", StTrap, 9'h005);
    chk("ecall_cause", 32'(trap_cause), 32'd11);
    nxt;

    fetch0(onehot(FlagEbreak), 1'b0);
    at("ebreak_trap", StTrap, 9'h005);
    chk("ebreak_cause", 32'(trap_cause), 32'd3);
    nxt;

    // wfi: ten cycles in SLEEP, irq in the tenth, then WB with PC+4
    fetch0(onehot(FlagWfi), 1'b0);
    for (int i = 0; i < 10; i++) begin
      irq = (i == 9);
      at("wfi_sleep", StSleep, 9'h000);
      nxt;
    end
    irq = 1'b0;
    at("wfi_wb", StWb, 9'h004);
    chk("wfi_pc_sel", 32'(pc_sel), 32'(PcPlus4));
    nxt;

    // Asynchronous reset during MWAIT; a late dmem_valid must be ignored
    fetch0(onehot(FlagLw), 1'b0);
    nxt;
    mem_if.dmem_ready = 1'b1;
    at("rlw_mem", StMem, 9'h020);
    nxt;
    mem_if.dmem_ready = 1'b0;
    at("rlw_mwait", StMWait, 9'h000);
    #2;
    rst_n = 1'b0;
    at("rlw_async_rst", StRst, 9'h000);
    chk("rlw_rst_wb_sel", 32'(wb_sel), 32'd0);
    nxt;
    rst_n = 1'b1;
    mem_if.dmem_valid = 1'b1;
    at("rlw_late_valid", StRst, 9'h000);
    nxt;
    mem_if.dmem_valid = 1'b0;
    at("rlw_after", StRst, 9'h000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: boot_en  in  1  leave reset state and begin fetching.
REQ-004 SHALL have port: imem_req  out  1  instruction fetch request, held until accepted.
REQ-005 SHALL have port: imem_ready  in  1  fetch request accepted this cycle.
REQ-006 SHALL have port: imem_valid  in  1  instruction word returned this cycle.
REQ-007 SHALL have port: ir_we  out  1  one-cycle pulse loading the instruction register.
REQ-008 SHALL have port: dec_en  out  1  decoder enable, high in DECODE only.
REQ-009 SHALL have port: inst_flags  in  48  one-hot decoder flags, bit indices per package constants.
REQ-010 SHALL have port: invalid_instruction  in  1  decoder illegal-instruction flag.
REQ-011 SHALL have port: br_taken  in  1  ALU branch-compare result, sampled in WB.
REQ-012 SHALL have port: dmem_req / dmem_we  out  1 / 1  data request and write qualifier.
REQ-013 SHALL have port: dmem_ready / dmem_valid  in  1 / 1  data accept / data response.
REQ-014 SHALL have port: rf_we  out  1  register-file write strobe.
REQ-015 SHALL have port: wb_sel  out  2  0 ALU, 1 MEM, 2 PC+4, 3 CSR.
REQ-016 SHALL have port: pc_we / pc_sel  out  1 / 2  PC update; 0 PC+4, 1 target, 2 trap vector, 3 epc.
REQ-017 SHALL have port: csr_we  out  1  CSR write strobe.
REQ-018 SHALL have port: trap_req / trap_cause  out  1 / 4  trap pulse and cause code.
REQ-019 SHALL have port: irq  in  1  level interrupt, wakes SLEEP only.
REQ-020 SHALL have port: state  out  4  current FSM state, debug.

Function
REQ-021 SHALL implement states RST, FETCH, FWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP, SLEEP.
REQ-022 SHALL go RST->FETCH when boot_en=1; boot_en ignored afterwards.
REQ-023 SHALL, in FETCH, assert imem_req; go FWAIT on imem_ready, else stay with req held.
REQ-024 SHALL, in FWAIT, pulse ir_we and go DECODE on imem_valid; imem_valid outside FWAIT ignored.
REQ-025 SHALL, in DECODE, latch inst_flags/invalid_instruction; priority: invalid->TRAP cause 2, ecall->TRAP cause 11, ebreak->TRAP cause 3, wfi->SLEEP, else EXEC.
REQ-026 SHALL leave EXEC after exactly 1 cycle: load/store->MEM, else WB.
REQ-027 SHALL, in MEM, assert dmem_req (dmem_we=1 for sb/sh/sw); go MWAIT on dmem_ready.
REQ-028 SHALL, in MWAIT, go WB on dmem_valid; dmem_valid elsewhere ignored.
REQ-029 SHALL, in WB (1 cycle), pulse pc_we; rf_we=1 for ALU/imm-ALU/lui/auipc/jal/jalr/load/CSR, 0 for branch/store/mret/sret/wfi; then FETCH.
REQ-030 SHALL select in WB: pc_sel=1 for jal, jalr, or branch with br_taken=1; 3 for mret/sret; else 0. wb_sel=1 load, 2 jal/jalr, 3 CSR, else 0.
REQ-031 SHALL pulse csr_we in WB for csrrw/s/c and immediate forms only.
REQ-032 SHALL, in TRAP (1 cycle), assert trap_req, pc_we, pc_sel=2, rf_we=0; then FETCH.
REQ-033 SHALL remain in SLEEP until irq=1, then WB (PC+4, no rf_we).
REQ-034 SHALL hold all strobes (ir_we, rf_we, pc_we, csr_we, trap_req, dec_en) 0 outside their state; none ever asserted together with trap_req except pc_we.
REQ-035 SHALL give minimum latency 5 cycles non-memory, 7 cycles load/store, with zero-wait-state memories.

Reset
REQ-036 SHALL on rst_n=0 immediately enter RST; all outputs 0, state=RST, latched flags cleared.
REQ-037 SHALL abandon any outstanding fetch or data access on reset; late imem_valid/dmem_valid after reset ignored.

Structure
REQ-038 SHALL place state enum, flag bit indices, trap cause codes, pc_sel/wb_sel encodings in package core_ctrl_pkg.
REQ-039 SHALL use one combinational sub-module wb_ctrl_map mapping latched flags plus br_taken to rf_we/wb_sel/pc_sel/csr_we.

Verification
REQ-040 SHALL test addi (0x00500093, addi flag), zero-wait memory -> rf_we=1, wb_sel=0, pc_sel=0 in cycle 5 after FETCH entry.
REQ-041 SHALL test lw with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, rf_we=1, wb_sel=1 in WB.
REQ-042 SHALL test beq with br_taken=1 then 0 -> pc_sel=1 then 0, rf_we=0 both.
REQ-043 SHALL test invalid_instruction=1 in DECODE -> trap_req=1, trap_cause=2, pc_sel=2, no rf_we.
REQ-044 SHALL test wfi then irq after 10 cycles -> state SLEEP 10 cycles, then WB pc_sel=0.
REQ-045 SHALL test rst_n low during MWAIT, dmem_valid pulsed after release -> outputs 0, state RST, no rf_we.
